aec_stream_eval: RTL and testbench

- Parametrised successor to the single-digit arithmetic expression calculator.
- Takes a streamed ASCII infix expression, one character per accepted beat, terminated by '='.
- Evaluates it with a two-stack, precedence-climbing engine: operand stack plus operator stack.
- Adds multi-digit decimal operands, signed DATA_W-bit results, flow control (in_valid/busy), configurable stack depth and an error flag.

---
 rtl/aec_stream_eval_if.sv | 22 ++
 rtl/aec_stream_eval.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_aec_stream_eval.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/aec_stream_eval_if.sv
// Character stream in, evaluated result out, for the streaming expression calculator.
interface aec_stream_eval_if #(
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic              in_valid;
   logic [7:0]        ascii_in;
   logic              busy;
   logic              valid;
   logic [DATA_W-1:0] result;
   logic              err;

   modport master (
      output start, in_valid, ascii_in,
      input  busy, valid, result, err
   );

   modport slave (
      input  start, in_valid, ascii_in,
      output busy, valid, result, err
   );
endinterface

// File: rtl/aec_stream_eval.sv
// Streaming infix evaluator: multi-digit operands, + - * with precedence, parentheses,
// operand/operator stacks, one reduction per cycle, sticky error reported at the end.
module aec_stream_eval #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned STACK_DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   aec_stream_eval_if.slave bus
);
   localparam int unsigned   CW      = $clog2(STACK_DEPTH + 1);
   localparam int unsigned   AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] TWO     = CW'(2);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PARSE  = 3'd1;
   localparam logic [2:0] ST_REDUCE = 3'd2;
   localparam logic [2:0] ST_FLUSH  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [2:0] OP_SENT = 3'd0;
   localparam logic [2:0] OP_LP   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;

   function automatic logic [1:0] prec(input logic [2:0] op);
      case (op)
         OP_MUL:         prec = 2'd2;
         OP_ADD, OP_SUB: prec = 2'd1;
         default:        prec = 2'd0;
      endcase
   endfunction

   function automatic logic is_arith(input logic [2:0] op);
      is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

   function automatic logic [DATA_W-1:0] apply(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD:  apply = a + b;
         OP_SUB:  apply = a - b;
         default: apply = a * b;
      endcase
   endfunction

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] opnd_q [STACK_DEPTH];
   logic [2:0]        op_q   [STACK_DEPTH];
   logic [CW-1:0]     opnd_cnt_q, opnd_cnt_d;
   logic [CW-1:0]     op_cnt_q, op_cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic [2:0]        lat_op_q, lat_op_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              res_err_q, res_err_d;

   logic              opnd_we, op_we;
   logic [AW-1:0]     opnd_widx, op_widx;
   logic [DATA_W-1:0] opnd_wdata;
   logic [2:0]        op_wdata;

   logic              busy_w, accept, fresh, is_digit, perr;
   logic [2:0]        ch_op;
   logic [CW-1:0]     e_opnd_cnt, e_op_cnt;
   logic [DATA_W-1:0] e_acc;
   logic              e_pend, e_err;
   logic [2:0]        e_top, top, nxt;
   logic              red_ok;
   logic [DATA_W-1:0] red_val;

   assign busy_w = (state_q == ST_REDUCE) || (state_q == ST_FLUSH) ||
                   (state_q == ST_DONE) || valid_q;
   assign accept = bus.in_valid && !busy_w;
   assign fresh  = accept && bus.start;

   // Operator stack slot 0 is an implicit bottom sentinel, counted but never stored.
   assign e_opnd_cnt = fresh ? '0 : opnd_cnt_q;
   assign e_op_cnt   = fresh ? ONE : op_cnt_q;
   assign e_acc      = fresh ? '0 : acc_q;
   assign e_pend     = fresh ? 1'b0 : pend_q;
   assign e_err      = fresh ? 1'b0 : err_q;
   assign e_top      = (e_op_cnt <= ONE) ? OP_SENT : op_q[AW'(e_op_cnt - ONE)];

   assign top     = (op_cnt_q <= ONE) ? OP_SENT : op_q[AW'(op_cnt_q - ONE)];
   assign nxt     = (op_cnt_q <= TWO) ? OP_SENT : op_q[AW'(op_cnt_q - TWO)];
   assign red_ok  = (opnd_cnt_q >= TWO);
   assign red_val = apply(top, opnd_q[AW'(opnd_cnt_q - TWO)], opnd_q[AW'(opnd_cnt_q - ONE)]);

   assign is_digit = (bus.ascii_in >= 8'h30) && (bus.ascii_in <= 8'h39);

   always_comb begin
      case (bus.ascii_in)
         8'h28:   ch_op = OP_LP;
         8'h2B:   ch_op = OP_ADD;
         8'h2D:   ch_op = OP_SUB;
         8'h2A:   ch_op = OP_MUL;
         default: ch_op = OP_SENT;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      opnd_cnt_d = opnd_cnt_q;
      op_cnt_d   = op_cnt_q;
      acc_d      = acc_q;
      pend_d     = pend_q;
      err_d      = err_q;
      lat_op_d   = lat_op_q;
      valid_d    = 1'b0;
      result_d   = result_q;
      res_err_d  = res_err_q;
      opnd_we    = 1'b0;
      opnd_widx  = '0;
      opnd_wdata = '0;
      op_we      = 1'b0;
      op_widx    = '0;
      op_wdata   = OP_SENT;
      perr       = 1'b0;

      case (state_q)
         ST_IDLE, ST_PARSE: begin
            if (accept && ((state_q == ST_PARSE) || bus.start)) begin
               state_d    = ST_PARSE;
               opnd_cnt_d = e_opnd_cnt;
               op_cnt_d   = e_op_cnt;
               acc_d      = e_acc;
               pend_d     = e_pend;
               err_d      = e_err;
               if (is_digit) begin
                  acc_d  = e_acc * DATA_W'(10) + DATA_W'(bus.ascii_in[3:0]);
                  pend_d = 1'b1;
               end else begin
                  acc_d  = '0;
                  pend_d = 1'b0;
                  perr   = e_err;
                  if (e_pend && !e_err) begin
                     if (e_opnd_cnt == DEPTH_C) begin
                        perr = 1'b1;
                     end else begin
                        opnd_we    = 1'b1;
                        opnd_widx  = AW'(e_opnd_cnt);
                        opnd_wdata = e_acc;
                        opnd_cnt_d = e_opnd_cnt + ONE;
                     end
                  end
                  if (bus.ascii_in == 8'h3D) begin
                     state_d = ST_FLUSH;
                  end else if (!perr) begin
                     if (ch_op != OP_SENT) begin
                        if ((ch_op != OP_LP) && (prec(e_top) >= prec(ch_op))) begin
                           lat_op_d = ch_op;
                           state_d  = ST_REDUCE;
                        end else if (e_op_cnt == DEPTH_C) begin
                           perr = 1'b1;
                        end else begin
                           op_we    = 1'b1;
                           op_widx  = AW'(e_op_cnt);
                           op_wdata = ch_op;
                           op_cnt_d = e_op_cnt + ONE;
                        end
                     end else if (bus.ascii_in == 8'h29) begin
                        // A pending ')' is latched as OP_LP for the REDUCE loop.
                        if (is_arith(e_top)) begin
                           lat_op_d = OP_LP;
                           state_d  = ST_REDUCE;
                        end else if (e_top == OP_LP) begin
                           op_cnt_d = e_op_cnt - ONE;
                        end else begin
                           perr = 1'b1;
                        end
                     end else if (bus.ascii_in != 8'h20) begin
                        perr = 1'b1;
                     end
                  end
                  err_d = perr;
               end
            end
         end

         ST_REDUCE: begin
            if (!red_ok) begin
               err_d   = 1'b1;
               state_d = ST_PARSE;
            end else begin
               opnd_we    = 1'b1;
               opnd_widx  = AW'(opnd_cnt_q - TWO);
               opnd_wdata = red_val;
               opnd_cnt_d = opnd_cnt_q - ONE;
               op_cnt_d   = op_cnt_q - ONE;
               // Decide on the entry below the popped operator so no idle cycle is spent.
               if (lat_op_q == OP_LP) begin
                  if (nxt == OP_LP) begin
                     op_cnt_d = op_cnt_q - TWO;
                     state_d  = ST_PARSE;
                  end else if (!is_arith(nxt)) begin
                     err_d   = 1'b1;
                     state_d = ST_PARSE;
                  end
               end else if (prec(nxt) < prec(lat_op_q)) begin
                  op_we    = 1'b1;
                  op_widx  = AW'(op_cnt_q - ONE);
                  op_wdata = lat_op_q;
                  op_cnt_d = op_cnt_q;
                  state_d  = ST_PARSE;
               end
            end
         end

         ST_FLUSH: begin
            if (err_q) begin
               state_d = ST_DONE;
            end else if (is_arith(top)) begin
               if (!red_ok) begin
                  err_d = 1'b1;
               end else begin
                  opnd_we    = 1'b1;
                  opnd_widx  = AW'(opnd_cnt_q - TWO);
                  opnd_wdata = red_val;
                  opnd_cnt_d = opnd_cnt_q - ONE;
                  op_cnt_d   = op_cnt_q - ONE;
               end
            end else begin
               err_d   = (top == OP_LP);
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            valid_d = 1'b1;
            state_d = ST_IDLE;
            if (err_q || (opnd_cnt_q != ONE)) begin
               result_d  = '0;
               res_err_d = 1'b1;
            end else begin
               result_d  = opnd_q[0];
               res_err_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         opnd_cnt_q <= '0;
         op_cnt_q   <= '0;
         acc_q      <= '0;
         pend_q     <= 1'b0;
         err_q      <= 1'b0;
         lat_op_q   <= OP_SENT;
         valid_q    <= 1'b0;
         result_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         opnd_cnt_q <= opnd_cnt_d;
         op_cnt_q   <= op_cnt_d;
         acc_q      <= acc_d;
         pend_q     <= pend_d;
         err_q      <= err_d;
         lat_op_q   <= lat_op_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         res_err_q  <= res_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (opnd_we) opnd_q[opnd_widx] <= opnd_wdata;
      if (op_we)   op_q[op_widx]     <= op_wdata;
   end

   assign bus.busy   = busy_w;
   assign bus.valid  = valid_q;
   assign bus.result = result_q;
   assign bus.err    = res_err_q;
endmodule

// File: tb/tb_aec_stream_eval.sv
// Directed bench for aec_stream_eval: two instances (stack depth 8 and 4), expected results
// queued as each expression is sent and compared whenever valid pulses.
module tb_aec_stream_eval;
   typedef struct packed {
      logic [15:0] res;
      logic        err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drv_start = 1'b0;
   logic       drv_valid = 1'b0;
   logic [7:0] drv_ascii = 8'h00;
   logic       unit_sel = 1'b0;
   logic       cur_busy;

   int   checks = 0;
   int   errors = 0;
   exp_t q8[$];
   exp_t q4[$];

   aec_stream_eval_if #(.DATA_W(16)) b8 ();
   aec_stream_eval_if #(.DATA_W(16)) b4 ();

   assign b8.start    = drv_start;
   assign b8.ascii_in = drv_ascii;
   assign b8.in_valid = drv_valid & ~unit_sel;
   assign b4.start    = drv_start;
   assign b4.ascii_in = drv_ascii;
   assign b4.in_valid = drv_valid & unit_sel;
   assign cur_busy    = unit_sel ? b4.busy : b8.busy;

   aec_stream_eval #(.DATA_W(16), .STACK_DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   aec_stream_eval #(.DATA_W(16), .STACK_DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input logic u);
      return u ? q4.size() : q8.size();
   endfunction

   task automatic expect_res(input logic [15:0] res, input logic err);
      exp_t e;
      e.res = res;
      e.err = err;
      if (unit_sel) q4.push_back(e);
      else          q8.push_back(e);
   endtask

   task automatic send(input string s, input logic st, input logic rnd, output int n_acc);
      logic got;
      n_acc = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (rnd && ($urandom_range(0, 1) == 1)) begin
            drv_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         drv_valid = 1'b1;
         drv_ascii = s[i];
         drv_start = st && (i == 0);
         got = 1'b0;
         for (int g = 0; g < 200 && !got; g++) begin
            got = !cur_busy;
            @(posedge clk);
            #1;
         end
         if (got) n_acc++;
         else     chk("accept_timeout", {31'd0, got}, 32'd1);
      end
      drv_valid = 1'b0;
      drv_start = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int g = 0; g < 300 && qsize(unit_sel) != 0; g++) begin
         @(posedge clk);
         #1;
      end
      chk(tag, qsize(unit_sel), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon8
      exp_t e;
      if (b8.valid === 1'b1) begin
         chk("valid8_expected", {31'd0, q8.size() != 0}, 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("result8", {16'd0, b8.result}, {16'd0, e.res});
            chk("err8", {31'd0, b8.err}, {31'd0, e.err});
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (b4.valid === 1'b1) begin
         chk("valid4_expected", {31'd0, q4.size() != 0}, 32'd1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("result4", {16'd0, b4.result}, {16'd0, e.res});
            chk("err4", {31'd0, b4.err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lat;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, b8.valid}, 32'd0);
      chk("rst_result", {16'd0, b8.result}, 32'd0);
      chk("rst_err", {31'd0, b8.err}, 32'd0);
      chk("rst_busy", {31'd0, b8.busy}, 32'd0);
      chk("rst_busy4", {31'd0, b4.busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Precedence and '=' to valid latency with two operators left on the stack
      expect_res(16'd11, 1'b0);
      send("3+4*2=", 1'b1, 1'b0, n);
      lat = 0;
      while (!b8.valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("t1_latency", lat, 4);
      drain("t1_drain");

      // Multi-digit, negative result, parentheses, then bubbles and reduction stalls
      expect_res(16'hFFE8, 1'b0);
      send("(12-20)*3=", 1'b1, 1'b0, n);
      drain("t2a_drain");
      expect_res(16'd9, 1'b0);
      send("2*(3+4)-5=", 1'b1, 1'b1, n);
      chk("t2_accepts", n, 10);
      drain("t2b_drain");

      // Wrap-around
      expect_res(16'd24464, 1'b0);
      send("300*300=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b0);
      send("65535+1=", 1'b1, 1'b0, n);
      drain("t3_drain");

      // Malformed expressions, then a good one clears the error
      expect_res(16'd0, 1'b1);
      send("((1+2)=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b1);
      send(")3=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b1);
      send("3 4=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b1);
      send("2#1=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b1);
      send("-3=", 1'b1, 1'b0, n);
      expect_res(16'd5, 1'b0);
      send("7-2=", 1'b1, 1'b0, n);
      drain("t4_drain");

      // Stack overflow boundaries on the depth-4 instance
      unit_sel = 1'b1;
      expect_res(16'd0, 1'b1);
      send("(((((1)))))=", 1'b1, 1'b0, n);
      expect_res(16'd0, 1'b1);
      send("((((1))))=", 1'b1, 1'b0, n);
      expect_res(16'd1, 1'b0);
      send("(((1)))=", 1'b1, 1'b0, n);
      drain("t5_drain");
      unit_sel = 1'b0;

      // Abort mid-expression: only the second expression reports
      expect_res(16'd81, 1'b0);
      send("1+2", 1'b1, 1'b0, n);
      send("9*9=", 1'b1, 1'b0, n);
      drain("t6a_drain");
      repeat (5) @(posedge clk);
      #1;

      // Reset while flushing: no valid, outputs cleared
      send("1+2*3=", 1'b1, 1'b0, n);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t6_rst_valid", {31'd0, b8.valid}, 32'd0);
      chk("t6_rst_result", {16'd0, b8.result}, 32'd0);
      chk("t6_rst_err", {31'd0, b8.err}, 32'd0);
      chk("t6_rst_busy", {31'd0, b8.busy}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      expect_res(16'hFFFE, 1'b0);
      send("8-10=", 1'b1, 1'b0, n);
      drain("t6b_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
